// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: request bundle, FSM states,
// wait counter and the address legality check.
package data_mem_responder_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] op_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  typedef logic [3:0] wait_cnt_t;

  typedef struct packed {
    logic       write;
    addr_t      addr;
    op_t        wdata;
    logic [3:0] be;
  } mem_req_t;

  localparam logic [3:0] BE_FULL = 4'hF;

  // Word-aligned and inside the stored range.
  function automatic logic addr_err(
    input addr_t       addr,
    input int unsigned depth
  );
    logic [31:0] word;
    word = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (word >= depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Single-port word RAM with byte write mask and registered read data.
// Contents are not reset.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  op_t           wdata,
  input  logic [3:0]    wmask,
  output op_t           rdata
);

  op_t mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready data-memory responder with WAIT_CYCLES wait states.
// Define DATA_MEM_BYTE_ENABLE_EN to add the req_be byte-enable port.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  addr_t      req_addr,
  input  op_t        req_wdata,
`ifdef DATA_MEM_BYTE_ENABLE_EN
  input  logic [3:0] req_be,
`endif
  output logic       resp_valid,
  input  logic       resp_ready,
  output op_t        resp_rdata,
  output logic       resp_err
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam wait_cnt_t CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : wait_cnt_t'(WAIT_CYCLES - 1);

  mem_state_t state_q, state_d;
  wait_cnt_t  cnt_q, cnt_d;
  mem_req_t   req_q, req_d;
  mem_req_t   in_req, sel_req;
  logic       load_q, load_d;
  logic       err_q, err_d;
  logic       commit, commit_err;
  logic       ram_we;
  op_t        ram_rdata;
  logic [3:0] in_be;

`ifdef DATA_MEM_BYTE_ENABLE_EN
  assign in_be = req_be;
`else
  assign in_be = BE_FULL;
`endif

  assign in_req = '{
    write: req_write,
    addr:  req_addr,
    wdata: req_wdata,
    be:    in_be
  };

  // Zero-wait requests commit straight from the port in IDLE.
  assign sel_req    = (state_q == IDLE) ? in_req : req_q;
  assign commit_err = addr_err(sel_req.addr, DEPTH_WORDS);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    load_d     = load_q;
    err_d      = err_q;
    commit     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d = in_req;
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
          load_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      load_d = !sel_req.write && !commit_err;
      err_d  = commit_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  // A reset on the commit edge must not let the store land.
  assign ram_we = commit && rst && sel_req.write && !commit_err;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .idx  (sel_req.addr[IW+1:2]),
    .wdata(sel_req.wdata),
    .wmask(sel_req.be),
    .rdata(ram_rdata)
  );

  assign resp_rdata = load_q ? ram_rdata : '0;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with two wait states, one with none.
// Byte-enable steps run when DATA_MEM_BYTE_ENABLE_EN is defined.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic clk;
  logic rst;

  logic       a_valid, a_ready, a_write;
  addr_t      a_addr;
  op_t        a_wdata, a_rdata;
  logic [3:0] a_be;
  logic       a_rv, a_rr, a_err;

  logic       z_valid, z_ready, z_write;
  addr_t      z_addr;
  op_t        z_wdata, z_rdata;
  logic [3:0] z_be;
  logic       z_rv, z_rr, z_err;

  int checks;
  int failures;

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(2)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (a_valid),
    .req_ready (a_ready),
    .req_write (a_write),
    .req_addr  (a_addr),
    .req_wdata (a_wdata),
`ifdef DATA_MEM_BYTE_ENABLE_EN
    .req_be    (a_be),
`endif
    .resp_valid(a_rv),
    .resp_ready(a_rr),
    .resp_rdata(a_rdata),
    .resp_err  (a_err)
  );

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (z_valid),
    .req_ready (z_ready),
    .req_write (z_write),
    .req_addr  (z_addr),
    .req_wdata (z_wdata),
`ifdef DATA_MEM_BYTE_ENABLE_EN
    .req_be    (z_be),
`endif
    .resp_valid(z_rv),
    .resp_ready(z_rr),
    .resp_rdata(z_rdata),
    .resp_err  (z_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and wait (bounded) for its response.
  task automatic do_req(
    input  bit         z,
    input  logic       wr,
    input  addr_t      ad,
    input  op_t        wd,
    input  logic [3:0] be,
    output op_t        rd,
    output logic       er,
    output int         cyc
  );
    if (z) begin
      z_valid = 1'b1; z_write = wr; z_addr = ad;
      z_wdata = wd; z_be = be;
    end else begin
      a_valid = 1'b1; a_write = wr; a_addr = ad;
      a_wdata = wd; a_be = be;
    end
    @(negedge clk);
    if (z) z_valid = 1'b0;
    else a_valid = 1'b0;
    cyc = 1;
    while (!(z ? z_rv : a_rv) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    rd = z ? z_rdata : a_rdata;
    er = z ? z_err : a_err;
    @(negedge clk);
  endtask

  op_t  rd;
  logic er;
  int   cyc;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    a_valid = 1'b0; a_write = 1'b0; a_addr = '0;
    a_wdata = '0; a_be = 4'hF; a_rr = 1'b1;
    z_valid = 1'b0; z_write = 1'b0; z_addr = '0;
    z_wdata = '0; z_be = 4'hF; z_rr = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_req_ready", 32'(a_ready), 32'd1);
    chk("rst_resp_valid", 32'(a_rv), 32'd0);
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_err", 32'(a_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, cyc);
    chk("st10_rdata", rd, 32'h0);
    chk("st10_err", 32'(er), 32'd0);
    chk("st10_lat", 32'(cyc), 32'd3);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, cyc);
    chk("ld10_rdata", rd, 32'hDEADBEEF);
    chk("ld10_err", 32'(er), 32'd0);
    chk("ld10_lat", 32'(cyc), 32'd3);

    do_req(0, 1'b1, 32'h0, 32'h12345678, 4'hF, rd, er, cyc);
    do_req(0, 1'b0, 32'h13, 32'h0, 4'hF, rd, er, cyc);
    chk("mis13_err", 32'(er), 32'd1);
    chk("mis13_rdata", rd, 32'h0);
    do_req(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, rd, er, cyc);
    chk("oor1000_err", 32'(er), 32'd1);
    chk("oor1000_rdata", rd, 32'h0);
    do_req(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, cyc);
    chk("ld0_rdata", rd, 32'h12345678);
    chk("ld0_err", 32'(er), 32'd0);

    // Response stall with a stray request pulse in the middle.
    a_rr = 1'b0;
    a_valid = 1'b1; a_write = 1'b0; a_addr = 32'h10;
    @(negedge clk);
    a_valid = 1'b0;
    cyc = 1;
    while (!a_rv && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_lat", 32'(cyc), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rv", 32'(a_rv), 32'd1);
      chk("stall_rdata", a_rdata, 32'hDEADBEEF);
      chk("stall_ready", 32'(a_ready), 32'd0);
      if (i == 1) begin
        a_valid = 1'b1; a_write = 1'b1;
        a_addr = 32'h10; a_wdata = 32'h0BAD0BAD;
      end else begin
        a_valid = 1'b0;
      end
      @(negedge clk);
    end
    a_valid = 1'b0;
    a_rr = 1'b1;
    @(negedge clk);
    chk("unstall_rv", 32'(a_rv), 32'd0);
    chk("unstall_ready", 32'(a_ready), 32'd1);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, cyc);
    chk("ld10_after_stall", rd, 32'hDEADBEEF);

    // Reset while a store sits in WAIT.
    do_req(0, 1'b1, 32'h20, 32'h1, 4'hF, rd, er, cyc);
    a_valid = 1'b1; a_write = 1'b1;
    a_addr = 32'h20; a_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_ready", 32'(a_ready), 32'd1);
    chk("midrst_rv", 32'(a_rv), 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_rv_late", 32'(a_rv), 32'd0);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, cyc);
    chk("ld20_after_rst", rd, 32'h1);

    // Zero-wait responder, back-to-back loads.
    do_req(1, 1'b1, 32'h4, 32'hA5A5A5A5, 4'hF, rd, er, cyc);
    chk("z_st4_lat", 32'(cyc), 32'd1);
    do_req(1, 1'b1, 32'h8, 32'h5A5A5A5A, 4'hF, rd, er, cyc);
    z_valid = 1'b1; z_write = 1'b0; z_addr = 32'h4;
    @(negedge clk);
    chk("z_b2b_rv0", 32'(z_rv), 32'd1);
    chk("z_b2b_ready0", 32'(z_ready), 32'd0);
    chk("z_b2b_rdata0", z_rdata, 32'hA5A5A5A5);
    z_addr = 32'h8;
    @(negedge clk);
    chk("z_b2b_rv1", 32'(z_rv), 32'd0);
    chk("z_b2b_ready1", 32'(z_ready), 32'd1);
    @(negedge clk);
    z_valid = 1'b0;
    chk("z_b2b_rv2", 32'(z_rv), 32'd1);
    chk("z_b2b_rdata2", z_rdata, 32'h5A5A5A5A);
    @(negedge clk);
    chk("z_b2b_idle", 32'(z_ready), 32'd1);

`ifdef DATA_MEM_BYTE_ENABLE_EN
    do_req(0, 1'b1, 32'h30, 32'h11223344, 4'hF, rd, er, cyc);
    do_req(0, 1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, rd, er, cyc);
    do_req(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, cyc);
    chk("be_merge", rd, 32'h11BB33DD);
    do_req(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, rd, er, cyc);
    chk("be_noop_err", 32'(er), 32'd0);
    do_req(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, cyc);
    chk("be_noop_data", rd, 32'h11BB33DD);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
